// File: rtl/seven_segment_capture_if.sv
// seven_segment_capture_if: display bus in, captured frame out with valid/ready.
interface seven_segment_capture_if #(parameter int NUM_DIGITS = 4);
  logic [6:0] segments;
  logic [NUM_DIGITS-1:0] anodes;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0] blank_mask;
  logic value_valid;
  logic value_ready;
  logic decode_err;
  logic overrun;
  modport master(output segments, anodes, value_ready, input value, blank_mask, value_valid, decode_err, overrun);
  modport slave(input segments, anodes, value_ready, output value, blank_mask, value_valid, decode_err, overrun);
endinterface

// File: rtl/seven_segment_capture.sv
// seven_segment_capture: decodes a multiplexed active-low 7-seg bus back into a BCD frame.
// Optional SEVEN_SEG_CAPTURE_ABORT_EN: an invalid pattern aborts the frame instead of storing E.
module seven_segment_capture #(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CYCLES = 16
) (
  input logic clk,
  input logic rst_n,
  seven_segment_capture_if.slave bus
);
  localparam int N = NUM_DIGITS;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam logic [7:0] CMAX = 8'(STABLE_CYCLES - 1);
  logic [6:0] r_seg;
  logic [N-1:0] r_an;
  logic [7:0] cnt;
  logic acc_done;
  logic [N-1:0] seen;
  logic [4*N-1:0] sh_val;
  logic [N-1:0] sh_blank;
  logic [3:0] nlow;
  logic [IW-1:0] idx;
  logic chg, single, multi, accept, invalid, blank, complete, multi_err;
  logic [3:0] nib;
  function automatic logic [5:0] dec(input logic [6:0] s);
    case (s)
      7'b0000001: dec = 6'h00;
      7'b1001111: dec = 6'h01;
      7'b0010010: dec = 6'h02;
      7'b0000110: dec = 6'h03;
      7'b1001100: dec = 6'h04;
      7'b0100100: dec = 6'h05;
      7'b0100000: dec = 6'h06;
      7'b0001111: dec = 6'h07;
      7'b0000000: dec = 6'h08;
      7'b0000100: dec = 6'h09;
      7'b1111111: dec = 6'h1F;
      default:    dec = 6'h2E;
    endcase
  endfunction
  always_comb begin
    nlow = '0;
    idx = '0;
    for (int k = 0; k < N; k++)
      if (!r_an[k]) begin
        nlow = nlow + 4'd1;
        idx = IW'(k);
      end
  end
  // The incoming sample is compared against the held one so a full dwell is accepted on the following edge.
  assign chg = {bus.segments, bus.anodes} != {r_seg, r_an};
  assign single = nlow == 4'd1;
  assign multi = nlow > 4'd1;
  assign {invalid, blank, nib} = dec(r_seg);
  assign accept = cnt == CMAX && single && !acc_done;
  assign multi_err = multi && !acc_done;
  assign complete = &seen;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= '1;
      r_an <= '1;
      cnt <= '0;
      acc_done <= 1'b0;
      seen <= '0;
      sh_val <= '0;
      sh_blank <= '0;
      bus.value <= '0;
      bus.blank_mask <= '0;
      bus.value_valid <= 1'b0;
      bus.decode_err <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      r_seg <= bus.segments;
      r_an <= bus.anodes;
      cnt <= chg ? 8'd0 : (cnt == CMAX ? cnt : cnt + 8'd1);
      acc_done <= chg ? 1'b0 : acc_done | accept | multi;
      bus.decode_err <= (accept && invalid) || multi_err;
      if (complete || multi_err)
        seen <= '0;
`ifdef SEVEN_SEG_CAPTURE_ABORT_EN
      else if (accept && invalid)
        seen <= '0;
      else if (accept)
        seen[idx] <= 1'b1;
      if (accept && !invalid) begin
`else
      else if (accept)
        seen[idx] <= 1'b1;
      if (accept) begin
`endif
        sh_val[4*idx +: 4] <= nib;
        sh_blank[idx] <= blank;
      end
      if (complete && (!bus.value_valid || bus.value_ready)) begin
        bus.value <= sh_val;
        bus.blank_mask <= sh_blank;
        bus.value_valid <= 1'b1;
      end else if (bus.value_valid && bus.value_ready)
        bus.value_valid <= 1'b0;
      if (complete && bus.value_valid && !bus.value_ready)
        bus.overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_seven_segment_capture.sv
// tb_seven_segment_capture: scoreboard bench with a digit-level reference model.
module tb_seven_segment_capture;
  localparam int N = 4;
  localparam int S = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  seven_segment_capture_if #(.NUM_DIGITS(N)) bus();
  seven_segment_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int fails = 0;
  int err_seen = 0;
  int err_exp = 0;
  logic ovr_exp = 1'b0;
  logic [4*N+N-1:0] expq[$];
  logic [6:0] seg_tab[10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
  logic [4*N-1:0] m_val = '0;
  logic [N-1:0] m_blank = '0;
  logic [N-1:0] m_seen = '0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // {invalid, blank, nibble} from the display's point of view
  function automatic logic [5:0] model_dec(input logic [6:0] p);
    if (p == 7'h7F) return 6'h1F;
    for (int d = 0; d < 10; d++) if (seg_tab[d] == p) return {2'b00, 4'(d)};
    return 6'h2E;
  endfunction
  function automatic logic [6:0] pat_of(input int c);
    return c == 10 ? 7'h7F : c == 11 ? 7'b1111110 : seg_tab[c];
  endfunction
  task automatic hold(input logic [6:0] s, input logic [N-1:0] a, input int n);
    bus.segments = s;
    bus.anodes = a;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic digit(input int i, input logic [6:0] pat, input int h, input int gap);
    logic [5:0] r;
    logic [N-1:0] a;
    if (h >= S) begin
      r = model_dec(pat);
      if (r[5]) err_exp++;
`ifdef SEVEN_SEG_CAPTURE_ABORT_EN
      if (r[5]) m_seen = '0;
      else begin
        m_val[4*i +: 4] = r[3:0];
        m_blank[i] = r[4];
        m_seen[i] = 1'b1;
      end
`else
      m_val[4*i +: 4] = r[3:0];
      m_blank[i] = r[4];
      m_seen[i] = 1'b1;
`endif
      if (&m_seen) begin
        if (!bus.value_ready && expq.size() != 0) ovr_exp = 1'b1;
        else expq.push_back({m_blank, m_val});
        m_seen = '0;
      end
    end
    a = '1;
    a[i] = 1'b0;
    hold(pat, a, h);
    if (gap > 0) hold(7'h7F, '1, gap);
  endtask
  task automatic scan(input int d0, input int d1, input int d2, input int d3);
    digit(0, pat_of(d0), 8, 2);
    digit(1, pat_of(d1), 8, 2);
    digit(2, pat_of(d2), 8, 2);
    digit(3, pat_of(d3), 8, 2);
  endtask
  logic [4*N+N-1:0] pv;
  logic pvalid = 1'b0;
  logic pready = 1'b0;
  always @(negedge clk) begin
    logic [4*N+N-1:0] e;
    if (!rst_n) pvalid = 1'b0;
    else begin
      if (bus.decode_err) err_seen++;
      if (pvalid && !pready) begin
        check("hold_valid", bus.value_valid, 1);
        check("hold_stable", {bus.blank_mask, bus.value}, pv);
      end
      if (bus.value_valid && bus.value_ready) begin
        if (expq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_frame: got %h expected none", {bus.blank_mask, bus.value});
        end else begin
          e = expq.pop_front();
          check("frame", {bus.blank_mask, bus.value}, e);
        end
      end
      pv = {bus.blank_mask, bus.value};
      pvalid = bus.value_valid;
      pready = bus.value_ready;
    end
  end
  initial begin
    int t;
    bus.segments = 7'h7F;
    bus.anodes = '1;
    bus.value_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_value", bus.value, 0);
    check("rst_blank", bus.blank_mask, 0);
    check("rst_valid", bus.value_valid, 0);
    check("rst_err", bus.decode_err, 0);
    check("rst_overrun", bus.overrun, 0);
    rst_n = 1'b1;
    hold(7'h7F, '1, 2);
    scan(4, 3, 2, 1);
    hold(7'h7F, '1, 6);
    check("err_clean_scan", err_seen, err_exp);
    digit(0, seg_tab[5], 3, 0);
    digit(0, seg_tab[9], 3, 2);
    digit(1, seg_tab[1], 8, 2);
    digit(2, seg_tab[2], 8, 2);
    digit(3, seg_tab[3], 8, 2);
    hold(7'h7F, '1, 4);
    check("short_dwell_no_frame", bus.value_valid, 0);
    digit(0, seg_tab[6], 5, 6);
    scan(0, 0, 7, 10);
    hold(7'h7F, '1, 6);
    scan(5, 11, 6, 8);
    hold(7'h7F, '1, 6);
    check("err_invalid", err_seen, err_exp);
    scan(9, 8, 7, 6);
    hold(7'h7F, '1, 6);
    bus.value_ready = 1'b0;
    scan(4, 3, 2, 1);
    scan(8, 7, 6, 5);
    hold(7'h7F, '1, 6);
    check("ovr_set", bus.overrun, ovr_exp);
    check("ovr_valid_held", bus.value_valid, 1);
    check("ovr_value_held", bus.value, 16'h1234);
    bus.value_ready = 1'b1;
    hold(7'h7F, '1, 1);
    check("ready_drops_valid", bus.value_valid, 0);
    check("ovr_sticky", bus.overrun, 1);
    digit(0, seg_tab[3], 8, 2);
    hold(seg_tab[3], 4'b1100, 8);
    err_exp++;
    m_seen = '0;
    hold(7'h7F, '1, 2);
    digit(1, seg_tab[1], 8, 2);
    digit(2, seg_tab[2], 8, 2);
    digit(3, seg_tab[3], 8, 2);
    hold(7'h7F, '1, 6);
    check("multi_no_frame", bus.value_valid, 0);
    check("err_multi", err_seen, err_exp);
    digit(0, seg_tab[0], 8, 6);
    for (int s = 0; s < 20; s++)
      for (int i = 0; i < N; i++)
        digit(i, pat_of($urandom_range(0, 15) == 0 ? 11 : $urandom_range(0, 10)),
              $urandom_range(3, 8), $urandom_range(0, 2));
    hold(7'h7F, '1, 8);
    check("err_random", err_seen, err_exp);
    digit(0, seg_tab[1], 8, 2);
    digit(1, seg_tab[2], 8, 2);
    bus.segments = seg_tab[3];
    bus.anodes = 4'b1011;
    rst_n = 1'b0;
    #1;
    check("async_rst_value", bus.value, 0);
    check("async_rst_valid", bus.value_valid, 0);
    check("async_rst_overrun", bus.overrun, 0);
    m_seen = '0;
    ovr_exp = 1'b0;
    hold(7'h7F, '1, 2);
    rst_n = 1'b1;
    digit(2, seg_tab[3], 8, 2);
    digit(3, seg_tab[4], 8, 2);
    hold(7'h7F, '1, 6);
    check("rst_discards_partial", bus.value_valid, 0);
    digit(0, seg_tab[1], 8, 2);
    digit(1, seg_tab[2], 8, 2);
    t = 0;
    while (expq.size() != 0 && t < 50) begin
      hold(7'h7F, '1, 1);
      t++;
    end
    if (expq.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending frames expected 0", expq.size());
    end
    hold(7'h7F, '1, 4);
    check("err_final", err_seen, err_exp);
    check("ovr_final", bus.overrun, ovr_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/seven_segment_capture.md
# seven_segment_capture

Monitors a multiplexed, active-low seven-segment display bus: per-digit segment patterns plus one-hot digit enables. It decodes each stable pattern back to a BCD nibble and assembles a full scan into one word, presented on a valid/ready interface. It sits on the display side of the segment decoders and lets the lifetime readout be checked or forwarded to the host exactly as displayed.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (1..8)
- STABLE_CYCLES, 16, consecutive identical samples required to accept a digit (2..255)
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- segments  in  7  active-low segments; bit 6 = a … bit 0 = g (segment lit when bit = 0)
- anodes  in  NUM_DIGITS  active-low digit enables; anodes[0] = least-significant digit
- value  out  4*NUM_DIGITS  captured word; nibble i = digit i
- blank_mask  out  NUM_DIGITS  bit i set when digit i was blank in the presented frame
- value_valid  out  1  frame available; held until accepted
- value_ready  in  1  consumer accepts frame when value_valid & value_ready
- decode_err  out  1  one-cycle pulse on an invalid pattern or a multi-digit enable
- overrun  out  1  sticky; a completed frame was dropped because the previous one was not yet accepted

## Operation
- Input stage: segments and anodes are registered once (r_seg, r_an). All logic uses the registered values.
- Stability counter (8 bit):
  - Cleared when {r_seg, r_an} differs from the previous sample.
  - Otherwise increments, saturating at STABLE_CYCLES-1.
  - An accept-done flag allows one accept per dwell; it clears on any change.
- Digit select: r_an exactly one bit low → digit index i.
  - All high: blanking interval; nothing captured.
  - More than one bit low: decode_err pulses once per dwell and the partial frame is aborted (seen cleared).
- Accept: counter == STABLE_CYCLES-1, single digit selected, accept-done clear. Decode table:
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9.
  - 1111111 → nibble F, blank bit set.
  - Any other pattern → nibble E, decode_err pulse (see Configuration).
  - The nibble and blank bit are written to shadow slot i and seen[i] is set. Re-accepting a digit in the same frame overwrites its slot.
- Frame complete when seen is all ones.
  - If value_valid is 0, or value_ready is 1 in that same cycle: on the next edge, shadow is copied to value/blank_mask, value_valid is set, and seen is cleared.
  - Otherwise the frame is dropped, seen is cleared, and overrun is set.
- Handshake: value_valid & value_ready → value_valid clears next edge unless a new frame loads on that same edge. value and blank_mask are stable while value_valid is high.
- overrun clears only on reset.

## Timing
- Reset values: value=0, blank_mask=0, value_valid=0, decode_err=0, overrun=0. Counter, seen, shadow and accept-done are all cleared.
- Reset asserted mid-frame discards the partial frame and any unaccepted frame.
- Input to accept: STABLE_CYCLES+1 edges after segments/anodes settle (1 register stage + STABLE_CYCLES samples).
- Last accept to value_valid high: 1 edge.
- decode_err is high exactly one cycle, coincident with the accept edge, or with the first edge a multi-low r_an is seen.
- Simultaneous accept of the last digit and consumer handshake: the new frame loads and value_valid stays high.

## Configuration
- SEVEN_SEG_CAPTURE_ABORT_EN:
  - Defined: an invalid pattern pulses decode_err, clears seen, and nothing is written to the shadow. The frame is aborted and a scan must restart.
  - Undefined: an invalid pattern pulses decode_err, stores nibble E, sets seen[i], and the frame completes normally.

## Test plan
- NUM_DIGITS=4, STABLE_CYCLES=4. Scan digits 0..3 with patterns for 4,3,2,1, 8 cycles each, 2 blank cycles between, value_ready=1 → value=16'h1234, blank_mask=0, value_valid pulses one cycle, decode_err never set.
- Digit 0 pattern held 3 cycles, then changed → no accept; seen[0] stays 0; no frame output until a 4+ cycle dwell occurs.
- Digit 3 driven 1111111, others 0,0,7 → value=16'hF700, blank_mask=4'b1000.
- Digit 1 driven 1111110: macro off → decode_err one pulse, value=16'h..E.; macro on → decode_err pulse, no frame after that scan, next clean scan produces a frame.
- value_ready=0, two complete scans 1234 then 5678 → value holds 16'h1234, overrun=1. Raise value_ready → value_valid low next edge, overrun stays 1.
- anodes=4'b1100 for 8 cycles mid-frame → single decode_err pulse, partial frame discarded. rst_n low mid-frame → all outputs 0 immediately (asynchronous).
